gemm_result_writeback: RTL

- Downstream stage of the GeMM controller and accumulator array.
- Captures each finished C block on the controller's result-valid pulse, together with its write-side M/N block indices.
- Computes the C SRAM block address and buffers the block in a small FIFO.
- Drains the FIFO to the C SRAM through a req/gnt handshake, and signals completion once the controller's done is seen and every buffered block has been written.

---
 rtl/gemm_result_writeback.sv | 122 ++++++++++++
 1 files changed

// File: rtl/gemm_result_writeback.sv
// C-block writeback: captures accumulator results with their block address,
// buffers them in a small FIFO and drains them to the C SRAM via req/gnt.
module gemm_result_writeback #(
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned DataWidth = 256,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic                           clear_i,
  input  logic                           result_valid_i,
  input  logic [DataWidth-1:0]           result_data_i,
  input  logic [AddrWidth-1:0]           M_count_i,
  input  logic [AddrWidth-1:0]           N_count_i,
  input  logic [AddrWidth-1:0]           N_size_i,
  input  logic [AddrWidth-1:0]           base_addr_i,
  input  logic                           done_i,
  output logic                           sram_req_o,
  input  logic                           sram_gnt_i,
  output logic [AddrWidth-1:0]           sram_addr_o,
  output logic [DataWidth-1:0]           sram_wdata_o,
  output logic                           sram_we_o,
  output logic                           busy_o,
  output logic                           wb_done_o,
  output logic                           overflow_o,
  output logic [$clog2(FifoDepth):0]     fill_o
);
  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam logic [PtrW:0]   Depth   = (PtrW+1)'(FifoDepth);
  localparam logic [PtrW:0]   CntOne  = (PtrW+1)'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {Idle, Active, Drain, Done} state_e;

  state_e          state_q, state_d;
  entry_t          mem_q [FifoDepth];
  entry_t          head;
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            full, pop, push, drop, wr_en;
  logic [2*AddrWidth-1:0] prod;
  logic [AddrWidth-1:0]   push_addr;

  // Full product kept wide; only the low half feeds the address (silent wrap).
  assign prod      = (2*AddrWidth)'(M_count_i) * (2*AddrWidth)'(N_size_i);
  assign push_addr = base_addr_i + prod[AddrWidth-1:0] + N_count_i;

  assign full  = (cnt_q == Depth);
  assign pop   = (cnt_q != '0) && sram_gnt_i;
  assign push  = result_valid_i && (!full || pop);
  assign drop  = result_valid_i && full && !pop;
  assign wr_en = push && !clear_i;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)          cnt_d = '0;
    else if (push && !pop) cnt_d = cnt_q + CntOne;
    else if (pop && !push) cnt_d = cnt_q - CntOne;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= '{addr: push_addr, data: result_data_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      state_q <= Idle;
    end else begin
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      if (clear_i) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + PtrOne;
        if (pop)  rptr_q <= rptr_q + PtrOne;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Idle:   if (start_i) state_d = Active;
      Active: if (done_i) state_d = Drain;
      Drain:  if (cnt_d == '0) state_d = Done;
      Done:   state_d = Idle;
      default: state_d = Idle;
    endcase
    if (clear_i) state_d = Idle;
  end

  // A drop in the same cycle as a new start belongs to the new job, so set wins.
  always_comb begin
    ovf_d = ovf_q;
    if (clear_i)                          ovf_d = 1'b0;
    else if (drop)                        ovf_d = 1'b1;
    else if (state_q == Idle && start_i)  ovf_d = 1'b0;
  end

  assign head         = mem_q[rptr_q];
  assign sram_req_o   = (cnt_q != '0);
  assign sram_we_o    = sram_req_o;
  assign sram_addr_o  = sram_req_o ? head.addr : '0;
  assign sram_wdata_o = sram_req_o ? head.data : '0;
  assign busy_o       = (state_q != Idle);
  assign wb_done_o    = (state_q == Done);
  assign overflow_o   = ovf_q;
  assign fill_o       = cnt_q;
endmodule
